// File: rtl/seven_segment_capture_if.sv
// Bus between a two-digit multiplexed seven-segment drive and its capture block.
// The master drives the display lines; the slave returns the reassembled frame and its status pulses.
interface seven_segment_capture_if;
    logic [3:0] sevenSegmentEnable;
    logic [7:0] sevenSegmentData;
    logic [3:0] segment2;
    logic [3:0] segment1;
    logic       frameValid;
    logic       decodeError;
    logic       frameTimeout;

    modport master (
        output sevenSegmentEnable, sevenSegmentData,
        input  segment2, segment1, frameValid, decodeError, frameTimeout
    );

    modport slave (
        input  sevenSegmentEnable, sevenSegmentData,
        output segment2, segment1, frameValid, decodeError, frameTimeout
    );
endinterface

// File: rtl/seven_segment_capture.sv
// Recovers the two digits from a multiplexed seven-segment display and reassembles them into frames.
// Optional macro SEVEN_SEGMENT_CHANGE_ONLY_EN: frameValid pulses only when the committed pair changes.
module seven_segment_capture #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned FRAME_TIMEOUT = 1024
) (
    input  logic                    clock,
    input  logic                    resetN,
    seven_segment_capture_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PARTIAL, COMMIT} state_t;

    localparam logic [3:0] EN_SEG2  = 4'b1101;
    localparam logic [3:0] EN_SEG1  = 4'b1110;
    localparam logic [7:0] STABLE_Q = 8'(STABLE_CYCLES);

    function automatic logic [4:0] decode(input logic [7:0] p);
        case (p)
            8'b10001000: decode = {1'b1, 4'h0};
            8'b11101011: decode = {1'b1, 4'h1};
            8'b01001100: decode = {1'b1, 4'h2};
            8'b01001001: decode = {1'b1, 4'h3};
            8'b00101011: decode = {1'b1, 4'h4};
            8'b00011001: decode = {1'b1, 4'h5};
            8'b00011000: decode = {1'b1, 4'h6};
            8'b11001011: decode = {1'b1, 4'h7};
            8'b00001000: decode = {1'b1, 4'h8};
            8'b00001001: decode = {1'b1, 4'h9};
            8'b00001010: decode = {1'b1, 4'hA};
            8'b00111000: decode = {1'b1, 4'hB};
            8'b10011100: decode = {1'b1, 4'hC};
            8'b01101000: decode = {1'b1, 4'hD};
            8'b00011100: decode = {1'b1, 4'hE};
            8'b00011110: decode = {1'b1, 4'hF};
            default:     decode = 5'b0_0000;
        endcase
    endfunction

    logic [3:0] en_q, prev_en;
    logic [7:0] data_q, prev_data;
    logic [7:0] cnt, cnt_next;
    logic       legal_q, same_q, hit;
    logic [4:0] dec_word;
    logic       cap_fire, cap_seg2, cap_ok;
    logic [3:0] cap_nib;
    logic       dec_err_q;

    assign legal_q  = (en_q == EN_SEG2) || (en_q == EN_SEG1);
    assign same_q   = (en_q == prev_en) && (data_q == prev_data);
    assign dec_word = decode(data_q);

    always_comb begin
        // NOTE: default assigned first so every path drives cnt_next and no latch is inferred.
        cnt_next = '0;
        if (legal_q)
            cnt_next = same_q ? ((cnt == STABLE_Q) ? cnt : cnt + 8'd1) : 8'd1;
    end

    // One capture per dwell: the count must newly arrive at the threshold, not sit saturated there.
    assign hit = legal_q && (cnt_next == STABLE_Q) && !(same_q && (cnt == STABLE_Q));

    // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            en_q      <= '0;
            data_q    <= '0;
            prev_en   <= '0;
            prev_data <= '0;
            cnt       <= '0;
            cap_fire  <= 1'b0;
            cap_seg2  <= 1'b0;
            cap_ok    <= 1'b0;
            cap_nib   <= '0;
            dec_err_q <= 1'b0;
        end else begin
            en_q      <= bus.sevenSegmentEnable;
            data_q    <= bus.sevenSegmentData;
            prev_en   <= en_q;
            prev_data <= data_q;
            cnt       <= cnt_next;
            cap_fire  <= hit;
            cap_seg2  <= (en_q == EN_SEG2);
            cap_ok    <= dec_word[4];
            cap_nib   <= dec_word[3:0];
            dec_err_q <= hit && !dec_word[4];
        end
    end

    state_t     state;
    logic [3:0] shadow2, shadow1, seg2_q, seg1_q;
    logic       flag2, flag1, valid_q, tout_q;
    logic [31:0] tcnt;
    logic       cap_take, completes, pulse;
    logic [3:0] commit2, commit1;

    assign cap_take  = cap_fire && cap_ok;
    assign completes = cap_seg2 ? !flag2 : !flag1;
    assign commit2   = cap_seg2 ? cap_nib : shadow2;
    assign commit1   = cap_seg2 ? shadow1 : cap_nib;

`ifdef SEVEN_SEGMENT_CHANGE_ONLY_EN
    logic seen_q;
    assign pulse = !seen_q || ({commit2, commit1} != {seg2_q, seg1_q});

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)
            seen_q <= 1'b0;
        else if (state == PARTIAL && cap_take && completes)
            seen_q <= 1'b1;
    end
`else
    assign pulse = 1'b1;
`endif

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            shadow2 <= '0;
            shadow1 <= '0;
            flag2   <= 1'b0;
            flag1   <= 1'b0;
            tcnt    <= '0;
            seg2_q  <= '0;
            seg1_q  <= '0;
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            tout_q  <= 1'b0;
            case (state)
                PARTIAL: begin
                    if (cap_take && completes) begin
                        seg2_q  <= commit2;
                        seg1_q  <= commit1;
                        valid_q <= pulse;
                        flag2   <= 1'b0;
                        flag1   <= 1'b0;
                        state   <= COMMIT;
                    end else begin
                        // Recapturing the held digit refreshes its nibble but keeps the timer running.
                        if (cap_take) begin
                            if (cap_seg2) shadow2 <= cap_nib;
                            else          shadow1 <= cap_nib;
                        end
                        if (FRAME_TIMEOUT != 0 && tcnt == FRAME_TIMEOUT - 1) begin
                            flag2  <= 1'b0;
                            flag1  <= 1'b0;
                            tout_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            tcnt <= tcnt + 32'd1;
                        end
                    end
                end
                default: begin
                    // IDLE and COMMIT both start a new frame from a fresh capture; flags are already clear.
                    state <= IDLE;
                    if (cap_take) begin
                        if (cap_seg2) begin
                            shadow2 <= cap_nib;
                            flag2   <= 1'b1;
                        end else begin
                            shadow1 <= cap_nib;
                            flag1   <= 1'b1;
                        end
                        tcnt  <= '0;
                        state <= PARTIAL;
                    end
                end
            endcase
        end
    end

    assign bus.segment2     = seg2_q;
    assign bus.segment1     = seg1_q;
    assign bus.frameValid   = valid_q;
    assign bus.decodeError  = dec_err_q;
    assign bus.frameTimeout = tout_q;
endmodule

// File: tb/tb_seven_segment_capture.sv
// Drives dwell sequences into seven_segment_capture and compares frames and status pulses
// against an event-level model of digit captures, frame assembly and timeouts.
module tb_seven_segment_capture;
    localparam int unsigned S  = 4;
    localparam int unsigned FT = 1024;

    logic clock  = 1'b0;
    logic resetN = 1'b0;

    seven_segment_capture_if bus();

    seven_segment_capture #(.STABLE_CYCLES(S), .FRAME_TIMEOUT(FT)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observed events, sampled on the falling edge.
    int unsigned obs_err = 0;
    int unsigned obs_to  = 0;
    logic [7:0]  obs_q[$];

    always @(negedge clock) begin
        if (bus.frameValid)   obs_q.push_back({bus.segment2, bus.segment1});
        if (bus.decodeError)  obs_err++;
        if (bus.frameTimeout) obs_to++;
    end

    // Reference model: works on capture events, indexed by the cycle each one completes.
    logic [7:0] pat_tab [16] = '{8'h88, 8'hEB, 8'h4C, 8'h49, 8'h2B, 8'h19, 8'h18, 8'hCB,
                                 8'h08, 8'h09, 8'h0A, 8'h38, 8'h9C, 8'h68, 8'h1C, 8'h1E};
    bit          m_partial = 0;
    int unsigned m_c0      = 0;
    bit          m_dig2    = 0;
    logic [3:0]  m_nib     = '0;
    logic [3:0]  m2 = '0, m1 = '0;
    bit          m_seen    = 0;
    logic [7:0]  exp_q[$];
    int unsigned exp_err = 0;
    int unsigned exp_to  = 0;
    int unsigned cyc     = 0;
    logic [3:0]  last_en   = 4'hF;
    logic [7:0]  last_data = 8'hFF;

    function automatic bit model_decode(input logic [7:0] p, output logic [3:0] n);
        n = '0;
        for (int i = 0; i < 16; i++)
            if (pat_tab[i] == p) begin
                n = 4'(i);
                return 1'b1;
            end
        return 1'b0;
    endfunction

    task automatic model_commit(input logic [3:0] a, input logic [3:0] b);
`ifdef SEVEN_SEGMENT_CHANGE_ONLY_EN
        if (!m_seen || {a, b} != {m2, m1}) exp_q.push_back({a, b});
`else
        exp_q.push_back({a, b});
`endif
        m2 = a;
        m1 = b;
        m_seen = 1;
        m_partial = 0;
    endtask

    task automatic model_capture(input int unsigned c, input logic [3:0] en, input logic [7:0] data);
        logic [3:0] n;
        bit d2;
        if (!model_decode(data, n)) begin
            exp_err++;
            return;
        end
        d2 = (en == 4'b1101);
        if (m_partial && FT > 0 && c - m_c0 > FT) begin
            exp_to++;
            m_partial = 0;
        end
        if (!m_partial) begin
            m_partial = 1;
            m_c0 = c;
            m_dig2 = d2;
            m_nib = n;
        end else if (d2 == m_dig2) begin
            if (FT > 0 && c - m_c0 == FT) begin
                exp_to++;
                m_partial = 0;
            end else begin
                m_nib = n;
            end
        end else begin
            if (d2) model_commit(n, m_nib);
            else    model_commit(m_nib, n);
        end
    endtask

    task automatic dwell(input logic [3:0] en, input logic [7:0] data, input int unsigned len);
        int unsigned s = cyc;
        bus.sevenSegmentEnable = en;
        bus.sevenSegmentData   = data;
        last_en = en;
        last_data = data;
        repeat (len) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        if (len >= S && (en == 4'b1101 || en == 4'b1110))
            model_capture(s + S - 1, en, data);
    endtask

    task automatic check_reset_state();
        check("rst_segment2", bus.segment2, 0);
        check("rst_segment1", bus.segment1, 0);
        check("rst_frameValid", bus.frameValid, 0);
        check("rst_decodeError", bus.decodeError, 0);
        check("rst_frameTimeout", bus.frameTimeout, 0);
    endtask

    task automatic do_reset();
        bus.sevenSegmentEnable = 4'hF;
        bus.sevenSegmentData   = 8'hFF;
        last_en = 4'hF;
        last_data = 8'hFF;
        resetN = 1'b0;
        @(posedge clock);
        #1;
        cyc++;
        resetN = 1'b1;
        m_partial = 0;
        m_seen = 0;
        m2 = '0;
        m1 = '0;
        check_reset_state();
    endtask

    task automatic settle(input string name);
        logic [7:0] o, e;
        dwell(4'hF, 8'hFF, 8);
        if (m_partial && FT > 0 && cyc - m_c0 > FT + 8) begin
            exp_to++;
            m_partial = 0;
        end
        check({name, "_decodeError_count"}, obs_err, exp_err);
        check({name, "_frameTimeout_count"}, obs_to, exp_to);
        check({name, "_frame_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({name, "_frame"}, o, e);
        end
        obs_q.delete();
        exp_q.delete();
        check({name, "_segment2"}, bus.segment2, m2);
        check({name, "_segment1"}, bus.segment1, m1);
    endtask

    initial begin
        logic [3:0] en;
        logic [7:0] data;
        int unsigned len;
        int unsigned r;

        bus.sevenSegmentEnable = 4'hF;
        bus.sevenSegmentData   = 8'hFF;
        repeat (3) @(posedge clock);
        #1;
        check_reset_state();
        resetN = 1'b1;

        // Basic frame 3/7.
        dwell(4'b1101, 8'h49, 8);
        dwell(4'b1110, 8'hCB, 8);
        settle("frame37");

        // Dwells one short of the threshold never capture.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            dwell(4'b1101, 8'h49, 3);
            dwell(4'b1110, 8'hCB, 3);
        end
        settle("short_dwell");

        // Undecodable stable pattern.
        dwell(4'b1101, 8'hFF, 8);
        settle("bad_pattern");

        // Partial frame (segment2=A) abandoned until timeout, then a normal frame.
        dwell(4'b1101, 8'h0A, 8);
        dwell(4'hF, 8'hFF, 1024);
        settle("timeout");
        dwell(4'b1110, 8'h2B, 8);
        dwell(4'b1101, 8'h9C, 8);
        settle("after_timeout");

        // Completing capture lands exactly on the timeout cycle.
        dwell(4'b1101, 8'h88, 4);
        dwell(4'hF, 8'hFF, FT - 4);
        dwell(4'b1110, 8'h1E, 4);
        settle("timeout_edge");

        // Identical frame twice after reset.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            dwell(4'b1101, 8'h49, 8);
            dwell(4'b1110, 8'hCB, 8);
        end
        settle("repeat_frame");

        // Reset discards a half-built frame.
        do_reset();
        dwell(4'b1101, 8'h0A, 8);
        do_reset();
        dwell(4'b1110, 8'hCB, 8);
        settle("reset_midframe");

        // Randomized dwells.
        for (int k = 0; k < 400; k++) begin
            do begin
                r = $urandom_range(0, 99);
                if (r < 45)      en = 4'b1101;
                else if (r < 90) en = 4'b1110;
                else begin
                    do en = 4'($urandom); while (en == 4'b1101 || en == 4'b1110);
                end
                if ($urandom_range(0, 99) < 85) data = pat_tab[$urandom_range(0, 15)];
                else                            data = 8'($urandom);
            end while (en == last_en && data == last_data);
            len = $urandom_range(1, 8);
            dwell(en, data, len);
            if (k % 50 == 49) settle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
